// File: rtl/neuron_array.sv
// neuron_array: NUM_NEURONS independent leaky integrate-and-fire channels,
// each with a four-state FSM (IDLE, SPIKE, REL_REF, ABS_REF).
// Optional build macro NEURON_SPIKE_COUNT_EN adds per-channel saturating
// spike counters with a shared clear input (clr_count).
module neuron_array #(
  parameter int NUM_NEURONS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int THRESH         = 15,
  parameter int THRESH_HIGH    = 40,
  parameter int OVERSHOOT      = 70,
  parameter int MAX_VAL        = 100,
  parameter int LEAK_IDLE      = 2,
  parameter int LEAK_REF       = 40,
  parameter int ABS_REF_CYCLES = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_NEURONS-1:0]            in_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_mac_sum,
  output logic [NUM_NEURONS-1:0]            out_spike,
  output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_vmem,
  output logic [2*NUM_NEURONS-1:0]          out_state,
  output logic                              spike_any
`ifdef NEURON_SPIKE_COUNT_EN
  ,
  input  logic                              clr_count,
  output logic [NUM_NEURONS*CNT_WIDTH-1:0]  out_spike_count
`endif
);

  localparam int EXT_W   = DATA_WIDTH + 2;
  localparam int DWELL_W = $clog2(ABS_REF_CYCLES + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SPIKE   = 2'd1;
  localparam logic [1:0] ST_REL_REF = 2'd2;
  localparam logic [1:0] ST_ABS_REF = 2'd3;

  localparam logic [DATA_WIDTH-1:0]   THRESH_V    = DATA_WIDTH'(THRESH);
  localparam logic [DATA_WIDTH-1:0]   THRESH_HI_V = DATA_WIDTH'(THRESH_HIGH);
  localparam logic [DATA_WIDTH-1:0]   OVERSHOOT_V = DATA_WIDTH'(OVERSHOOT);
  localparam logic [DATA_WIDTH-1:0]   MAX_V       = DATA_WIDTH'(MAX_VAL);
  localparam logic signed [EXT_W-1:0] MAX_E       = EXT_W'(MAX_VAL);
  localparam logic signed [EXT_W-1:0] LEAK_IDLE_E = EXT_W'(LEAK_IDLE);
  localparam logic signed [EXT_W-1:0] LEAK_REF_E  = EXT_W'(LEAK_REF);
  localparam logic [DWELL_W-1:0]      DWELL_EXIT  = DWELL_W'(ABS_REF_CYCLES - 1);

  // Clamp the widened signed membrane update into [0, MAX_VAL].
  function automatic logic [DATA_WIDTH-1:0] clamp_vmem(input logic signed [EXT_W-1:0] s);
    if (s < 0)          return '0;
    else if (s > MAX_E) return MAX_V;
    else                return s[DATA_WIDTH-1:0];
  endfunction

  logic [1:0]               state_q     [NUM_NEURONS];
  logic [1:0]               state_d     [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]    vmem_q      [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]    vmem_d      [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]    pre_spike_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]    pre_spike_d [NUM_NEURONS];
  logic [DWELL_W-1:0]       dwell_q     [NUM_NEURONS];
  logic [DWELL_W-1:0]       dwell_d     [NUM_NEURONS];
  logic signed [EXT_W-1:0]  in_ext      [NUM_NEURONS];
  logic signed [EXT_W-1:0]  vmem_ext    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]   spike_q;
  logic [NUM_NEURONS-1:0]   spike_d;
  logic                     spike_any_q;
  logic                     spike_any_d;

  // Per-channel input sign extension and output packing.
  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_ch
    assign in_ext[g]   = in_valid[g]
                       ? {{2{in_mac_sum[g*DATA_WIDTH + DATA_WIDTH - 1]}}, in_mac_sum[g*DATA_WIDTH +: DATA_WIDTH]}
                       : '0;
    assign vmem_ext[g] = {2'b00, vmem_q[g]};
    assign out_vmem[g*DATA_WIDTH +: DATA_WIDTH] = vmem_q[g];
    assign out_state[2*g +: 2]                  = state_q[g];
  end

  assign out_spike = spike_q;
  assign spike_any = spike_any_q;

  // Next-state and membrane update; transitions look only at registered values.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      state_d[i]     = state_q[i];
      vmem_d[i]      = vmem_q[i];
      pre_spike_d[i] = pre_spike_q[i];
      dwell_d[i]     = dwell_q[i];
      case (state_q[i])
        ST_IDLE: begin
          vmem_d[i] = clamp_vmem(vmem_ext[i] + in_ext[i] - LEAK_IDLE_E);
          if (vmem_q[i] >= THRESH_V) begin
            state_d[i]     = ST_SPIKE;
            pre_spike_d[i] = vmem_q[i];
          end
        end
        ST_SPIKE: begin
          // Dwell counter is cleared here so ABS_REF always starts from zero.
          dwell_d[i] = '0;
          state_d[i] = (pre_spike_q[i] >= OVERSHOOT_V) ? ST_ABS_REF : ST_REL_REF;
        end
        ST_REL_REF: begin
          vmem_d[i] = clamp_vmem(vmem_ext[i] + in_ext[i] - LEAK_REF_E);
          if (vmem_q[i] == '0) begin
            state_d[i] = ST_IDLE;
          end else if (vmem_q[i] >= THRESH_HI_V) begin
            state_d[i]     = ST_SPIKE;
            pre_spike_d[i] = vmem_q[i];
          end
        end
        default: begin
          vmem_d[i] = clamp_vmem(vmem_ext[i] - LEAK_REF_E);
          if (dwell_q[i] != '1) dwell_d[i] = dwell_q[i] + DWELL_W'(1);
          if ((dwell_q[i] >= DWELL_EXIT) && (vmem_q[i] == '0)) state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  // Registered spike follows the state being entered, so it is high exactly in SPIKE.
  always_comb begin
    spike_d = '0;
    for (int i = 0; i < NUM_NEURONS; i++) spike_d[i] = (state_d[i] == ST_SPIKE);
    spike_any_d = |spike_d;
  end

  // Channel state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i]     <= ST_IDLE;
        vmem_q[i]      <= '0;
        pre_spike_q[i] <= '0;
        dwell_q[i]     <= '0;
      end
      spike_q     <= '0;
      spike_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i]     <= state_d[i];
        vmem_q[i]      <= vmem_d[i];
        pre_spike_q[i] <= pre_spike_d[i];
        dwell_q[i]     <= dwell_d[i];
      end
      spike_q     <= spike_d;
      spike_any_q <= spike_any_d;
    end
  end

`ifdef NEURON_SPIKE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_NEURONS];

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
    assign out_spike_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  // Saturating spike counters; clear takes priority over a coincident spike.
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr_count)                          cnt_d[i] = '0;
      else if (spike_d[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule

// File: doc/neuron_array.md
NEURON_ARRAY -- requirements
Module: neuron_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of independent neuron channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: membrane and input width.
REQ-003 SHALL have parameters THRESH=15, THRESH_HIGH=40, OVERSHOOT=70, MAX_VAL=100, LEAK_IDLE=2 and LEAK_REF=40, with the same meanings as the single-neuron block.
REQ-004 SHALL have parameter ABS_REF_CYCLES, default 3: minimum number of cycles spent in ABS_REF.
REQ-005 SHALL have parameter CNT_WIDTH, default 8: spike counter width.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, NUM_NEURONS bits: per-channel input valid.
REQ-009 SHALL have port in_mac_sum, input, NUM_NEURONS*DATA_WIDTH bits: per-channel signed two's-complement input; channel i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port out_spike, output, NUM_NEURONS bits: per-channel registered spike.
REQ-011 SHALL have port out_vmem, output, NUM_NEURONS*DATA_WIDTH bits: per-channel unsigned membrane potential, with the same packing as in_mac_sum.
REQ-012 SHALL have port out_state, output, 2*NUM_NEURONS bits: per-channel FSM state.
REQ-013 SHALL have port spike_any, output, 1 bit: registered OR of all spikes.
REQ-014 SHALL have port clr_count, input, 1 bit, only when SPIKE_COUNT_EN is defined: clears all spike counters.
REQ-015 SHALL have port out_spike_count, output, NUM_NEURONS*CNT_WIDTH bits, only when SPIKE_COUNT_EN is defined: per-channel spike counts.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE=0, SPIKE=1, REL_REF=2 and ABS_REF=3.
REQ-017 Next state SHALL be decided from the registered vmem and state, not from the value being written.
REQ-018 The vmem update SHALL use a signed intermediate of DATA_WIDTH+2 bits and clamp the result to [0, MAX_VAL].
REQ-019 Accumulated input SHALL be the sign-extended in_mac_sum when in_valid is 1, and 0 otherwise.
REQ-020 IDLE: vmem <= clamp(vmem + input - LEAK_IDLE).
REQ-021 IDLE: when vmem >= THRESH, the channel SHALL go to SPIKE and capture pre_spike <= vmem.
REQ-022 SPIKE: vmem SHALL be held and input ignored.
REQ-023 SPIKE: the channel SHALL go to ABS_REF if pre_spike >= OVERSHOOT, else to REL_REF.
REQ-024 REL_REF: vmem <= clamp(vmem + input - LEAK_REF); input is accepted in this state.
REQ-025 REL_REF: vmem == 0 SHALL go to IDLE; otherwise vmem >= THRESH_HIGH SHALL go to SPIKE and capture pre_spike.
REQ-026 ABS_REF: input SHALL be ignored and vmem <= clamp(vmem - LEAK_REF).
REQ-027 ABS_REF: a dwell counter SHALL be cleared on entry and incremented each cycle, saturating.
REQ-028 ABS_REF: the channel SHALL exit to IDLE only when the dwell counter >= ABS_REF_CYCLES-1 and vmem == 0.
REQ-029 out_spike[i] SHALL be 1 exactly in the cycles where channel i is in SPIKE.
REQ-030 Timing SHALL be: threshold reached at edge k, out_spike high after edge k+1, low after edge k+2.
REQ-031 spike_any SHALL equal the OR of the out_spike values being registered at the same edge.
REQ-032 out_vmem and out_state SHALL be direct views of the registers.
REQ-033 Channels SHALL NOT interact; simultaneous spikes on several channels SHALL each be reported.

Reset
REQ-034 On rst=1 at a clock edge, every channel SHALL return to IDLE with vmem=0, pre_spike=0 and dwell counter=0.
REQ-035 On that same edge, out_spike, spike_any and all spike counters SHALL be 0.
REQ-036 A reset asserted in any state, including mid-SPIKE or mid-ABS_REF, SHALL take effect at the next edge and drop any in-flight spike.
REQ-037 in_valid SHALL be ignored while rst=1.

Configuration
REQ-038 With macro NEURON_SPIKE_COUNT_EN defined, each channel SHALL have a CNT_WIDTH saturating counter that increments on each cycle out_spike[i] is registered high.
REQ-039 With NEURON_SPIKE_COUNT_EN defined, clr_count SHALL zero all counters, and clr_count SHALL win over a simultaneous increment.
REQ-040 With NEURON_SPIKE_COUNT_EN undefined, clr_count, out_spike_count and the counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-041 Relative-refractory path (ch0): +10 valid for 2 cycles, then idle.
- Required: vmem 8, 16, then SPIKE with vmem=14, pre=16, out_spike=1 for one cycle.
- Then REL_REF with vmem 14 → 0, then IDLE.
REQ-042 Absolute-refractory path (ch1): +90 for 1 cycle.
- Required: vmem=88, then SPIKE (vmem 86), then ABS_REF with vmem 46, 6, 0.
- IDLE is entered no earlier than 3 cycles after entering ABS_REF.
- +50 applied during ABS_REF has no effect.
REQ-043 Negative input and saturation:
- vmem=8 with -20 valid → 0.
- +127 for two cycles from 0 → 100 (MAX_VAL), never wraps.
REQ-044 REL_REF re-spike: during REL_REF with vmem=14, inject +80.
- Required: vmem=54, then SPIKE, since 54 >= THRESH_HIGH.
REQ-045 Independence and reset:
- ch0 and ch3 reach threshold at the same edge → out_spike=4'b1001, spike_any=1.
- rst asserted during SPIKE → next edge all outputs 0 and all channels IDLE.
REQ-046 With NEURON_SPIKE_COUNT_EN defined:
- 3 spikes on ch2 → count 3.
- clr_count coincident with a 4th spike → count 0.
- 300 spikes with CNT_WIDTH=8 → count 255.
